// File: rtl/bidin_ldpc_feeder_if.sv
// Port bundle between the LDPC feeder, the main-memory read port, the frame-ready source and the decoder.
interface bidin_ldpc_feeder_if #(
    parameter int WID = 6,
    parameter int AW  = 18
);
    logic           frame_rdy;
    logic           ldpc_req;
    logic           ldpc_stall;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_addr;
    logic [WID-1:0] mem_rdata;
    logic           ldpc_vld;
    logic           ldpc_sob;
    logic           ldpc_eob;
    logic [WID-1:0] ldpc_dout;
    logic [3:0]     blk_idx;
    logic           busy;
    logic           err_ovf;

    // Symbol handshake: a symbol moves on a rising clk edge where ldpc_vld=1 and ldpc_stall=0;
    // while ldpc_vld=1 and ldpc_stall=1 the payload (dout/sob/eob) holds. Memory returns
    // mem_rdata exactly one cycle after a mem_rd_en cycle, with no back-pressure.
    modport master (
        input  frame_rdy, ldpc_req, ldpc_stall, mem_rdata,
        output mem_rd_en, mem_addr, ldpc_vld, ldpc_sob, ldpc_eob, ldpc_dout,
               blk_idx, busy, err_ovf
    );

    modport slave (
        output frame_rdy, ldpc_req, ldpc_stall, mem_rdata,
        input  mem_rd_en, mem_addr, ldpc_vld, ldpc_sob, ldpc_eob, ldpc_dout,
               blk_idx, busy, err_ovf
    );
endinterface

// File: rtl/bidin_ldpc_feeder.sv
// Streams a deinterleaved frame from main memory to the LDPC decoder, one codeword per ldpc_req.
// Optional macro BIDIN_FEED_RESTART_EN: frame_rdy while busy restarts the frame instead of being ignored.
module bidin_ldpc_feeder #(
    parameter int WID     = 6,
    parameter int AW      = 18,
    parameter int BLK_LEN = 9216,
    parameter int NUM_BLK = 15
) (
    input  logic                clk,
    input  logic                rst,
    bidin_ldpc_feeder_if.master bus,
    output logic [1:0]          state_o
);
    localparam int              OFF_W    = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BLK_LEN - 1);
    localparam logic [3:0]      BLK_LAST = 4'(NUM_BLK - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_REQ = 2'd1,
        S_READ     = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t           state_q;
    logic [3:0]       blk_idx_q;
    logic [OFF_W-1:0] offset_q;
    logic [AW-1:0]    addr_q;
    logic             inflight_q;
    logic             infl_sob_q;
    logic             infl_eob_q;
    logic             err_ovf_q;

    logic [WID-1:0]   skid_data_q [2];
    logic             skid_sob_q  [2];
    logic             skid_eob_q  [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;

    logic             vld;
    logic             pop;
    logic             issue;
    logic [1:0]       occ;
    logic [1:0]       cnt_d;

    // A slot freed by this cycle's pop may be reused by this cycle's read, which keeps 1 symbol/cycle.
    always_comb begin
        vld   = (cnt_q != 2'd0);
        pop   = vld && !bus.ldpc_stall;
        occ   = cnt_q + {1'b0, inflight_q};
        issue = (state_q == S_READ) && ((occ < 2'd2) || pop);
        case ({inflight_q, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            blk_idx_q  <= 4'd0;
            offset_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            infl_sob_q <= 1'b0;
            infl_eob_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_data_q[i] <= '0;
                skid_sob_q[i]  <= 1'b0;
                skid_eob_q[i]  <= 1'b0;
            end
        end else begin
            if (inflight_q) begin
                skid_data_q[wr_ptr_q] <= bus.mem_rdata;
                skid_sob_q[wr_ptr_q]  <= infl_sob_q;
                skid_eob_q[wr_ptr_q]  <= infl_eob_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q      <= cnt_d;
            inflight_q <= issue;
            infl_sob_q <= (offset_q == '0);
            infl_eob_q <= (offset_q == OFF_LAST);
            if (issue) begin
                addr_q   <= addr_q + AW'(1);
                offset_q <= (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.frame_rdy) begin
                        state_q   <= S_WAIT_REQ;
                        blk_idx_q <= 4'd0;
                        offset_q  <= '0;
                        addr_q    <= '0;
                    end
                end
                S_WAIT_REQ: begin
                    if (bus.ldpc_req) begin
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue && (offset_q == OFF_LAST)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_d == 2'd0) begin
                        if (blk_idx_q == BLK_LAST) begin
                            state_q   <= S_IDLE;
                            blk_idx_q <= 4'd0;
                            addr_q    <= '0;
                        end else begin
                            state_q   <= S_WAIT_REQ;
                            blk_idx_q <= blk_idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (bus.frame_rdy && (state_q != S_IDLE)) begin
                err_ovf_q <= 1'b1;
`ifdef BIDIN_FEED_RESTART_EN
                // Abort: drop skid contents and the read in flight, restart from codeword 0.
                state_q    <= S_WAIT_REQ;
                blk_idx_q  <= 4'd0;
                offset_q   <= '0;
                addr_q     <= '0;
                inflight_q <= 1'b0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                cnt_q      <= 2'd0;
`endif
            end
        end
    end

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = addr_q;
    assign bus.ldpc_vld  = vld;
    assign bus.ldpc_sob  = vld && skid_sob_q[rd_ptr_q];
    assign bus.ldpc_eob  = vld && skid_eob_q[rd_ptr_q];
    assign bus.ldpc_dout = skid_data_q[rd_ptr_q];
    assign bus.blk_idx   = blk_idx_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err_ovf   = err_ovf_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_bidin_ldpc_feeder.sv
// Directed bench for bidin_ldpc_feeder with a short frame (3 codewords of 16 symbols).
module tb_bidin_ldpc_feeder;
    localparam int WID     = 6;
    localparam int AW      = 18;
    localparam int BLK_LEN = 16;
    localparam int NUM_BLK = 3;
    localparam int TOTAL   = BLK_LEN * NUM_BLK;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bidin_ldpc_feeder_if #(.WID(WID), .AW(AW)) bus ();

    bidin_ldpc_feeder #(
        .WID(WID), .AW(AW), .BLK_LEN(BLK_LEN), .NUM_BLK(NUM_BLK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .state_o(state_o)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: data = low address bits; junk on cycles without a read.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[WID-1:0];
        else               bus.mem_rdata <= WID'($urandom);
    end

    // ---------------- output monitor ----------------
    logic [WID-1:0] obs_data_q[$];
    logic           obs_sob_q[$];
    logic           obs_eob_q[$];
    logic [3:0]     obs_blk_q[$];
    int             obs_cyc_q[$];

    int             outstanding = 0;
    int             max_out     = 0;
    int             stab_err    = 0;
    bit             chk_en      = 1'b0;
    bit             prev_hold   = 1'b0;
    logic [WID+1:0] prev_pay;

    always @(negedge clk) begin
        if (!rst && bus.ldpc_vld && !bus.ldpc_stall) begin
            obs_data_q.push_back(bus.ldpc_dout);
            obs_sob_q.push_back(bus.ldpc_sob);
            obs_eob_q.push_back(bus.ldpc_eob);
            obs_blk_q.push_back(bus.blk_idx);
            obs_cyc_q.push_back(cyc);
        end
        if (rst) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(bus.mem_rd_en)
                          - int'(bus.ldpc_vld && !bus.ldpc_stall);
        end
        if (outstanding > max_out) max_out = outstanding;
        if (chk_en && prev_hold) begin
            if (!bus.ldpc_vld || ({bus.ldpc_dout, bus.ldpc_sob, bus.ldpc_eob} != prev_pay))
                stab_err++;
        end
        prev_hold = !rst && bus.ldpc_vld && bus.ldpc_stall;
        prev_pay  = {bus.ldpc_dout, bus.ldpc_sob, bus.ldpc_eob};
    end

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        obs_data_q.delete();
        obs_sob_q.delete();
        obs_eob_q.delete();
        obs_blk_q.delete();
        obs_cyc_q.delete();
    endtask

    // Leaves the caller 1 time unit after the edge that accepted frame_rdy.
    task automatic start_frame();
        @(posedge clk); #1 bus.frame_rdy = 1'b1;
        @(posedge clk); #1 bus.frame_rdy = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok, output int fall_cyc);
        ok = 1'b0;
        fall_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                fall_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_pops(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (obs_data_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.frame_rdy  = 1'b0;
        bus.ldpc_req   = 1'b0;
        bus.ldpc_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_eob, bus.busy, bus.err_ovf, bus.mem_rd_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_eob, bus.busy, bus.err_ovf, bus.mem_rd_en});
        end
        n_checks++;
        if ({bus.mem_addr, bus.ldpc_dout, bus.blk_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: got addr %0h dout %0h blk %0d expected all 0",
                     bus.mem_addr, bus.ldpc_dout, bus.blk_idx);
        end
        n_checks++;
        if (state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", state_o);
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        int fall;
        int gap_err;
        logic [WID-1:0] exp_q[$];
        clear_obs();
        bus.ldpc_req   = 1'b1;
        bus.ldpc_stall = 1'b0;
        start_frame();
        n_checks++;
        if ({state_o, bus.busy, bus.mem_rd_en} !== {2'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ff_wait_req: got state %0d busy %b rd %b expected 1 1 0",
                     state_o, bus.busy, bus.mem_rd_en);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({state_o, bus.mem_rd_en, bus.mem_addr} !== {2'd2, 1'b1, 18'd0}) begin
            n_fail++;
            $display("FAIL ff_first_read: got state %0d rd %b addr %0d expected 2 1 0",
                     state_o, bus.mem_rd_en, bus.mem_addr);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.ldpc_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_vld_early: got %b expected 0", bus.ldpc_vld);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_dout} !== {1'b1, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL ff_first_sym: got vld %b sob %b dout %0d expected 1 1 0",
                     bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_dout);
        end
        wait_idle(400, ok, fall);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ff_timeout: busy still %b expected 0", bus.busy);
        end
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(WID'(i));
        n_checks++;
        if (obs_data_q.size() !== TOTAL) begin
            n_fail++;
            $display("FAIL ff_count: got %0d expected %0d", obs_data_q.size(), TOTAL);
        end
        for (int i = 0; i < TOTAL && i < obs_data_q.size(); i++) begin
            n_checks++;
            if ({obs_data_q[i], obs_sob_q[i], obs_eob_q[i], obs_blk_q[i]} !==
                {exp_q[i], (i % BLK_LEN) == 0, (i % BLK_LEN) == BLK_LEN - 1, 4'(i / BLK_LEN)}) begin
                n_fail++;
                $display("FAIL ff_sym%0d: got data %0d sob %b eob %b blk %0d expected %0d %b %b %0d",
                         i, obs_data_q[i], obs_sob_q[i], obs_eob_q[i], obs_blk_q[i], exp_q[i],
                         (i % BLK_LEN) == 0, (i % BLK_LEN) == BLK_LEN - 1, i / BLK_LEN);
            end
        end
        if (obs_cyc_q.size() == TOTAL) begin
            gap_err = 0;
            for (int i = 1; i < TOTAL; i++)
                if ((i % BLK_LEN) != 0 && obs_cyc_q[i] != obs_cyc_q[i-1] + 1) gap_err++;
            n_checks++;
            if (gap_err !== 0) begin
                n_fail++;
                $display("FAIL ff_throughput: got %0d gaps inside blocks expected 0", gap_err);
            end
            n_checks++;
            if (fall !== obs_cyc_q[TOTAL-1] + 1) begin
                n_fail++;
                $display("FAIL ff_busy_fall: got cycle %0d expected %0d", fall, obs_cyc_q[TOTAL-1] + 1);
            end
        end
    endtask

    task automatic test_req_gap();
        bit ok;
        int fall;
        int viol;
        clear_obs();
        bus.ldpc_req   = 1'b1;
        bus.ldpc_stall = 1'b0;
        start_frame();
        wait_pops(BLK_LEN, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL gap_blk0_timeout: got %0d symbols expected %0d", obs_data_q.size(), BLK_LEN);
        end
        bus.ldpc_req = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_rd_en) viol++;
        end
        n_checks++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL gap_idle_reads: got %0d reads expected 0", viol);
        end
        n_checks++;
        if ({state_o, bus.blk_idx, 6'(obs_data_q.size())} !== {2'd1, 4'd1, 6'(BLK_LEN)}) begin
            n_fail++;
            $display("FAIL gap_parked: got state %0d blk %0d syms %0d expected 1 1 %0d",
                     state_o, bus.blk_idx, obs_data_q.size(), BLK_LEN);
        end
        bus.ldpc_req = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 18'd16}) begin
            n_fail++;
            $display("FAIL gap_blk1_read: got rd %b addr %0d expected 1 16", bus.mem_rd_en, bus.mem_addr);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.ldpc_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_vld_early: got %b expected 0", bus.ldpc_vld);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_dout} !== {1'b1, 1'b1, 6'd16}) begin
            n_fail++;
            $display("FAIL gap_blk1_first: got vld %b sob %b dout %0d expected 1 1 16",
                     bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_dout);
        end
        wait_idle(400, ok, fall);
        n_checks++;
        if (!ok || obs_data_q.size() !== TOTAL) begin
            n_fail++;
            $display("FAIL gap_frame_end: got done %b syms %0d expected 1 %0d", ok, obs_data_q.size(), TOTAL);
        end
        for (int i = 0; i < obs_data_q.size(); i++) begin
            n_checks++;
            if (obs_data_q[i] !== WID'(i)) begin
                n_fail++;
                $display("FAIL gap_sym%0d: got %0d expected %0d", i, obs_data_q[i], i);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_obs();
        chk_en   = 1'b1;
        max_out  = 0;
        stab_err = 0;
        bus.ldpc_req = 1'b1;
        start_frame();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.ldpc_stall = 1'($urandom_range(0, 1));
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.ldpc_stall = 1'b0;
        chk_en = 1'b0;
        n_checks++;
        if (!ok || obs_data_q.size() !== TOTAL) begin
            n_fail++;
            $display("FAIL stall_frame_end: got done %b syms %0d expected 1 %0d", ok, obs_data_q.size(), TOTAL);
        end
        for (int i = 0; i < obs_data_q.size(); i++) begin
            n_checks++;
            if ({obs_data_q[i], obs_sob_q[i], obs_eob_q[i]} !==
                {WID'(i), (i % BLK_LEN) == 0, (i % BLK_LEN) == BLK_LEN - 1}) begin
                n_fail++;
                $display("FAIL stall_sym%0d: got data %0d sob %b eob %b expected %0d",
                         i, obs_data_q[i], obs_sob_q[i], obs_eob_q[i], i);
            end
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL stall_stability: got %0d payload changes expected 0", stab_err);
        end
        n_checks++;
        if (max_out > 2) begin
            n_fail++;
            $display("FAIL stall_outstanding: got %0d expected at most 2", max_out);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int fall;
        int n_pre;
        int n_tot;
        int j;
        clear_obs();
        bus.ldpc_req   = 1'b1;
        bus.ldpc_stall = 1'b0;
        start_frame();
        n_checks++;
        if (bus.err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_before: got %b expected 0", bus.err_ovf);
        end
        wait_pops(20, 200, ok);
        bus.frame_rdy = 1'b1;
        @(posedge clk); #1 bus.frame_rdy = 1'b0;
        n_checks++;
        if (!ok || bus.err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got reached %b err_ovf %b expected 1 1", ok, bus.err_ovf);
        end
`ifdef BIDIN_FEED_RESTART_EN
        n_pre = 21;
        n_checks++;
        if ({state_o, 7'(obs_data_q.size())} !== {2'd1, 7'd21}) begin
            n_fail++;
            $display("FAIL ovf_restart_state: got state %0d syms %0d expected 1 21", state_o, obs_data_q.size());
        end
`else
        n_pre = 0;
`endif
        n_tot = n_pre + TOTAL;
        wait_idle(400, ok, fall);
        n_checks++;
        if (!ok || obs_data_q.size() !== n_tot) begin
            n_fail++;
            $display("FAIL ovf_frame_end: got done %b syms %0d expected 1 %0d", ok, obs_data_q.size(), n_tot);
        end
        for (int i = 0; i < obs_data_q.size(); i++) begin
            j = (i < n_pre) ? i : i - n_pre;
            n_checks++;
            if ({obs_data_q[i], obs_sob_q[i]} !== {WID'(j), (j % BLK_LEN) == 0}) begin
                n_fail++;
                $display("FAIL ovf_sym%0d: got data %0d sob %b expected %0d %b",
                         i, obs_data_q[i], obs_sob_q[i], j, (j % BLK_LEN) == 0);
            end
        end
        n_checks++;
        if (bus.err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", bus.err_ovf);
        end
    endtask

    task automatic test_rst_mid_frame();
        bit ok;
        int fall;
        clear_obs();
        bus.ldpc_req   = 1'b1;
        bus.ldpc_stall = 1'b0;
        start_frame();
        wait_pops(10, 200, ok);
        bus.ldpc_stall = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (!ok || {bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_eob, bus.busy, bus.err_ovf, bus.mem_rd_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_flags: got reached %b flags %b expected 1 000000", ok,
                     {bus.ldpc_vld, bus.ldpc_sob, bus.ldpc_eob, bus.busy, bus.err_ovf, bus.mem_rd_en});
        end
        n_checks++;
        if ({state_o, bus.mem_addr, bus.ldpc_dout, bus.blk_idx} !== '0) begin
            n_fail++;
            $display("FAIL rst_buses: got state %0d addr %0d dout %0d blk %0d expected all 0",
                     state_o, bus.mem_addr, bus.ldpc_dout, bus.blk_idx);
        end
        rst = 1'b0;
        bus.ldpc_stall = 1'b0;
        clear_obs();
        start_frame();
        wait_idle(400, ok, fall);
        n_checks++;
        if (!ok || obs_data_q.size() !== TOTAL) begin
            n_fail++;
            $display("FAIL rst_new_frame: got done %b syms %0d expected 1 %0d", ok, obs_data_q.size(), TOTAL);
        end
        for (int i = 0; i < obs_data_q.size(); i++) begin
            n_checks++;
            if ({obs_data_q[i], obs_sob_q[i]} !== {WID'(i), (i % BLK_LEN) == 0}) begin
                n_fail++;
                $display("FAIL rst_sym%0d: got data %0d sob %b expected %0d", i, obs_data_q[i], obs_sob_q[i], i);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_full_frame();
        test_req_gap();
        test_stall();
        test_overflow();
        test_rst_mid_frame();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
